crono_countdown: RTL and testbench

- Countdown engine that consumes the BCD HH:MM:SS value produced by the chronometer set/edit block.
- Captures the value on a load pulse and decrements it once per 1 Hz tick while running.
- Raises an alarm when the count reaches 00:00:00.
- Drives the display mux and the buzzer enable in place of the edit block's outputs whenever the timer screen is active.

---
 rtl/crono_countdown.sv | 187 ++++++++++++++++++
 tb/tb_crono_countdown.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crono_countdown.sv
// crono_countdown: BCD HH:MM:SS countdown timer for the chronometer timer screen.
// Captures the edit block's value on load, counts down on the 1 Hz tick while
// running, and holds an alarm for ALARM_TICKS ticks once the count hits zero.
module crono_countdown #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] h_in,
    input  logic [7:0] m_in,
    input  logic [7:0] s_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [7:0] h_out,
    output logic [7:0] m_out,
    output logic [7:0] s_out,
    output logic       running,
    output logic       alarm,
    output logic       load_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RUN    = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] h_q, h_d, m_q, m_d, s_q, s_d;
    logic [7:0] acnt_q, acnt_d;
    logic       running_q, running_d;
    logic       alarm_q, alarm_d;
    logic       lerr_q, lerr_d;
    logic       ss_ref_q, clr_ref_q;

    logic        ss_edge, clr_edge, tick_go, load_go;
    logic        load_valid, load_nonzero;
    logic [23:0] dec_val;

    // One-second BCD decrement as a ripple of borrows from seconds units upward.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [3:0] ht, hu, mt, mu, st, su;
        logic       b;
        {ht, hu, mt, mu, st, su} = v;
        b = 1'b1;
        if (su == 4'd0) su = 4'd9; else begin su = su - 4'd1; b = 1'b0; end
        if (b) begin
            if (st == 4'd0) st = 4'd5; else begin st = st - 4'd1; b = 1'b0; end
        end
        if (b) begin
            if (mu == 4'd0) mu = 4'd9; else begin mu = mu - 4'd1; b = 1'b0; end
        end
        if (b) begin
            if (mt == 4'd0) mt = 4'd5; else begin mt = mt - 4'd1; b = 1'b0; end
        end
        if (b) begin
            if (hu == 4'd0) hu = 4'd9; else begin hu = hu - 4'd1; b = 1'b0; end
        end
        if (b) ht = ht - 4'd1;
        return {ht, hu, mt, mu, st, su};
    endfunction

    // Qualified events: everything is masked while the block is disabled.
    always_comb begin
        ss_edge  = en & start_stop & ~ss_ref_q;
        clr_edge = en & clear & ~clr_ref_q;
        tick_go  = en & tick;
        load_go  = en & load;
        load_valid = (h_in[3:0] <= 4'd9) && (m_in[3:0] <= 4'd9) && (s_in[3:0] <= 4'd9)
                  && (m_in[7:4] <= 4'd5) && (s_in[7:4] <= 4'd5) && (h_in <= 8'h23);
        load_nonzero = |{h_in, m_in, s_in};
        dec_val      = bcd_dec({h_q, m_q, s_q});
    end

    // Next-state, next-count and registered-output decode.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        acnt_d  = acnt_q;
        lerr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_edge) begin
                    {h_d, m_d, s_d} = '0;
                end else if (load_go) begin
                    if (!load_valid) begin
                        lerr_d = 1'b1;
                    end else if (load_nonzero) begin
                        {h_d, m_d, s_d} = {h_in, m_in, s_in};
                        state_d         = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (clr_edge) begin
                    {h_d, m_d, s_d} = '0;
                    state_d         = ST_IDLE;
                end else if (ss_edge) begin
                    state_d = ST_RUN;
                end else if (load_go) begin
                    if (!load_valid) begin
                        lerr_d = 1'b1;
                    end else begin
                        {h_d, m_d, s_d} = {h_in, m_in, s_in};
                        if (!load_nonzero) state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (clr_edge) begin
                    {h_d, m_d, s_d} = '0;
                    state_d         = ST_IDLE;
                end else if (ss_edge) begin
                    state_d = ST_PAUSED;
                end else if (tick_go) begin
                    {h_d, m_d, s_d} = dec_val;
                    if (dec_val == '0) begin
                        state_d = ST_ALARM;
                        acnt_d  = 8'(ALARM_TICKS);
                    end
                end
            end
            ST_ALARM: begin
                {h_d, m_d, s_d} = '0;
                if (clr_edge || ss_edge) begin
                    state_d = ST_IDLE;
                    acnt_d  = '0;
                end else if (tick_go) begin
                    acnt_d = acnt_q - 8'd1;
                    if (acnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        acnt_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    // State, count and flag registers; button references track inputs even when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            m_q       <= '0;
            s_q       <= '0;
            acnt_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            lerr_q    <= 1'b0;
            ss_ref_q  <= 1'b0;
            clr_ref_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            m_q       <= m_d;
            s_q       <= s_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            lerr_q    <= lerr_d;
            ss_ref_q  <= start_stop;
            clr_ref_q <= clear;
        end
    end

    // Output mapping.
    always_comb begin
        h_out    = h_q;
        m_out    = m_q;
        s_out    = s_q;
        running  = running_q;
        alarm    = alarm_q;
        load_err = lerr_q;
        state    = state_q;
    end

endmodule

// File: tb/tb_crono_countdown.sv
// tb_crono_countdown: directed scenarios plus randomized traffic, checked every
// cycle against a seconds-based behavioural model of the countdown timer.
module tb_crono_countdown;

    localparam int AT = 5;

    logic       clk = 1'b0;
    logic       reset, en, tick, load, start_stop, clear;
    logic [7:0] h_in, m_in, s_in, h_out, m_out, s_out;
    logic       running, alarm, load_err;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count kept as plain seconds.
    int m_state, m_secs, m_acnt;
    bit m_ss_prev, m_clr_prev, m_lerr;

    crono_countdown #(.ALARM_TICKS(AT)) dut (
        .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
        .h_in(h_in), .m_in(m_in), .s_in(s_in),
        .start_stop(start_stop), .clear(clear),
        .h_out(h_out), .m_out(m_out), .s_out(s_out),
        .running(running), .alarm(alarm), .load_err(load_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int to_secs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (int'(h[7:4]) * 10 + int'(h[3:0])) * 3600
             + (int'(m[7:4]) * 10 + int'(m[3:0])) * 60
             + (int'(s[7:4]) * 10 + int'(s[3:0]));
    endfunction

    function automatic bit is_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (h[3:0] > 9 || h[7:4] > 9 || m[3:0] > 9 || s[3:0] > 9) return 0;
        if (m[7:4] > 5 || s[7:4] > 5) return 0;
        return (int'(h[7:4]) * 10 + int'(h[3:0])) <= 23;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        bit ss_e, clr_e, tk, ld;
        int v;
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_secs = 0; m_acnt = 0;
            m_ss_prev = 0; m_clr_prev = 0; m_lerr = 0;
        end else begin
            ss_e  = en && start_stop && !m_ss_prev;
            clr_e = en && clear && !m_clr_prev;
            tk    = en && tick;
            ld    = en && load;
            m_ss_prev  = start_stop;
            m_clr_prev = clear;
            m_lerr     = 0;
            v = to_secs(h_in, m_in, s_in);
            case (m_state)
                0: begin
                    if (clr_e) m_secs = 0;
                    else if (ld) begin
                        if (!is_valid(h_in, m_in, s_in)) m_lerr = 1;
                        else if (v != 0) begin m_secs = v; m_state = 1; end
                    end
                end
                1: begin
                    if (clr_e) begin m_secs = 0; m_state = 0; end
                    else if (ss_e) m_state = 2;
                    else if (ld) begin
                        if (!is_valid(h_in, m_in, s_in)) m_lerr = 1;
                        else begin m_secs = v; if (v == 0) m_state = 0; end
                    end
                end
                2: begin
                    if (clr_e) begin m_secs = 0; m_state = 0; end
                    else if (ss_e) m_state = 1;
                    else if (tk) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin m_state = 3; m_acnt = AT; end
                    end
                end
                default: begin
                    if (clr_e || ss_e) m_state = 0;
                    else if (tk) begin
                        m_acnt = m_acnt - 1;
                        if (m_acnt == 0) m_state = 0;
                    end
                end
            endcase
        end
        #1;
        check("state", 32'(state), 32'(m_state));
        check("hms", 32'({h_out, m_out, s_out}), 32'(to_bcd(m_secs)));
        check("running", 32'(running), 32'(m_state == 2));
        check("alarm", 32'(alarm), 32'(m_state == 3));
        check("load_err", 32'(load_err), 32'(m_lerr));
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cycle(); tick = 1'b0; cycle();
    endtask

    task automatic press_ss();
        start_stop = 1'b1; cycle(); start_stop = 1'b0; cycle();
    endtask

    task automatic press_clr();
        clear = 1'b1; cycle(); clear = 1'b0; cycle();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        h_in = h; m_in = m; s_in = s;
        load = 1'b1; cycle(); load = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; tick = 1'b0; load = 1'b0;
        start_stop = 1'b0; clear = 1'b0;
        h_in = '0; m_in = '0; s_in = '0;
        cycle(); cycle();
        check("rst_state", 32'(state), 32'd0);
        check("rst_hms", 32'({h_out, m_out, s_out}), 32'h0);
        reset = 1'b0;
        cycle();

        // 00:01:05 down through the minute borrow
        do_load(8'h00, 8'h01, 8'h05);
        check("load_paused", 32'(state), 32'd1);
        press_ss();
        for (int i = 0; i < 5; i++) pulse_tick();
        check("tick5_hms", 32'({h_out, m_out, s_out}), 32'h000100);
        pulse_tick();
        check("tick6_hms", 32'({h_out, m_out, s_out}), 32'h000059);
        press_clr();

        // full borrow chain
        do_load(8'h01, 8'h00, 8'h00);
        press_ss();
        pulse_tick();
        check("chain_hms", 32'({h_out, m_out, s_out}), 32'h005959);
        press_clr();
        check("clr_idle", 32'(state), 32'd0);

        // alarm timeout
        do_load(8'h00, 8'h00, 8'h02);
        press_ss();
        pulse_tick(); pulse_tick();
        check("alarm_state", 32'(state), 32'd3);
        check("alarm_flag", 32'(alarm), 32'd1);
        for (int i = 0; i < AT - 1; i++) pulse_tick();
        check("alarm_hold", 32'(state), 32'd3);
        pulse_tick();
        check("alarm_done", 32'(state), 32'd0);

        // alarm cancelled by start_stop at alarm tick 3
        do_load(8'h00, 8'h00, 8'h02);
        press_ss();
        pulse_tick(); pulse_tick();
        pulse_tick(); pulse_tick();
        start_stop = 1'b1; tick = 1'b1; cycle();
        check("alarm_cancel", 32'(state), 32'd0);
        check("alarm_cancel_flag", 32'(alarm), 32'd0);
        start_stop = 1'b0; tick = 1'b0; cycle();

        // rejected loads
        do_load(8'h00, 8'h00, 8'h30);
        h_in = 8'h24; m_in = 8'h00; s_in = 8'h00; load = 1'b1; cycle();
        check("err_h_pulse", 32'(load_err), 32'd1);
        load = 1'b0; cycle();
        check("err_h_drop", 32'(load_err), 32'd0);
        check("err_h_hms", 32'({h_out, m_out, s_out}), 32'h000030);
        h_in = 8'h00; m_in = 8'h6A; s_in = 8'h00; load = 1'b1; cycle();
        check("err_m_pulse", 32'(load_err), 32'd1);
        load = 1'b0; cycle();
        check("err_m_state", 32'(state), 32'd1);

        // start_stop beats tick; clear beats start_stop
        do_load(8'h00, 8'h00, 8'h10);
        press_ss();
        start_stop = 1'b1; tick = 1'b1; cycle();
        start_stop = 1'b0; tick = 1'b0; cycle();
        check("ss_tick_state", 32'(state), 32'd1);
        check("ss_tick_hms", 32'({h_out, m_out, s_out}), 32'h000010);
        press_ss();
        start_stop = 1'b1; clear = 1'b1; cycle();
        start_stop = 1'b0; clear = 1'b0; cycle();
        check("clr_ss_state", 32'(state), 32'd0);
        check("clr_ss_hms", 32'({h_out, m_out, s_out}), 32'h0);

        // disabled block freezes
        do_load(8'h00, 8'h00, 8'h30);
        press_ss();
        pulse_tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; start_stop = ~start_stop; cycle();
            tick = 1'b0; cycle();
        end
        start_stop = 1'b0; cycle();
        en = 1'b1;
        check("en_state", 32'(state), 32'd2);
        check("en_hms", 32'({h_out, m_out, s_out}), 32'h000029);
        pulse_tick();
        check("en_resume", 32'({h_out, m_out, s_out}), 32'h000028);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            tick = ($urandom_range(0, 3) == 0);
            load = 1'b0;
            if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
            else if ($urandom_range(0, 24) == 0) clear = ~clear;
            else if (en && $urandom_range(0, 5) == 0) begin
                load = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin h_in = 8'($urandom); m_in = 8'($urandom); s_in = 8'($urandom); end
                    1: {h_in, m_in, s_in} = to_bcd($urandom_range(0, 25));
                    2: {h_in, m_in, s_in} = to_bcd($urandom_range(0, 86399));
                    default: {h_in, m_in, s_in} = to_bcd($urandom_range(0, 5));
                endcase
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
